mc_ctrl_fsm: RTL and testbench
==============================

# mc_ctrl_fsm

Multi-cycle control unit with instruction register for the 16-bit RISC computer.
- Sequences each instruction through fetch, decode, execute, memory and writeback states.
- Latches the fetched word into the instruction register and drives `Instr` and `Imm_Sel` directly into the immediate generator.
- Drives all datapath enables and mux selects, and handshakes with a variable-latency memory through `Mem_Req`/`Mem_Ready`.

## Interface
- No parameters. Opcode map and encodings below are fixed.
- `Clk`  in  1  system clock; all registers update on its rising edge.
- `Rst_n`  in  1  asynchronous, active-low reset.
- `Mem_Ready`  in  1  memory completes the current request this cycle.
- `Mem_Rdata`  in  16  memory read data; valid when `Mem_Ready`=1.
- `Zero`  in  1  ALU zero flag.
- `Instr`  out  16  instruction register contents; feeds the immediate generator and register-file address fields.
- `Imm_Sel`  out  2  immediate format select:
  - 00 I-format
  - 01 load/store offset
  - 10 branch offset
  - 11 jump target
- `Mem_Req`, `Mem_We`, `IorD`  out  1 each  memory request, write enable, address select (0 = PC, 1 = ALUOut).
- `IR_Write`, `PC_Write`, `Reg_Write`, `MemtoReg`  out  1 each.
- `ALU_SrcA`  out  1  0 = PC, 1 = register A.
- `ALU_SrcB`  out  2  00 = register B, 01 = constant 1, 11 = `Imm_Out`.
- `ALU_Op`  out  2  00 add, 01 sub, 10 funct field.
- `PC_Src`  out  2  00 ALU result, 01 ALUOut, 10 `Imm_Out`.
- `Halted`, `Illegal`  out  1 each  sticky status flags.
- `State`  out  4  current state encoding, for debug.

## Operation
- Opcode is `Instr[15:12]`:
  - 0000 R-type
  - 0001 ADDI
  - 0010 LW
  - 0011 SW
  - 0100 BEQ
  - 0101 JMP
  - 1111 HALT
  - All other values are illegal.
- State encodings: FETCH=0, DECODE=1, EXEC_R=2, EXEC_I=3, MEM_ADDR=4, MEM_RD=5, MEM_WR=6, WB_ALU=7, WB_MEM=8, BRANCH=9, JUMP=10, HALT=11, ILLEGAL=12. Encodings 13–15 go to ILLEGAL.
- Outputs are combinational from state and are 0 unless listed below. `IR_Write` and `PC_Write` are additionally gated by `Mem_Ready` or `Zero` where noted.
- FETCH:
  - `Mem_Req`=1, `IorD`=0, `ALU_SrcA`=0, `ALU_SrcB`=01, `ALU_Op`=00, `PC_Src`=00.
  - If `Mem_Ready`=1: `IR_Write`=`PC_Write`=1, `Instr`<=`Mem_Rdata`, go to DECODE. Otherwise stay in FETCH.
- DECODE:
  - `ALU_SrcA`=0, `ALU_SrcB`=11, `Imm_Sel`=10, `ALU_Op`=00 (precomputes the branch target).
  - Next state by opcode: R-type → EXEC_R; ADDI → EXEC_I; LW/SW → MEM_ADDR; BEQ → BRANCH; JMP → JUMP; HALT → HALT; all others → ILLEGAL.
- EXEC_R: `ALU_SrcA`=1, `ALU_SrcB`=00, `ALU_Op`=10 → WB_ALU.
- EXEC_I: `ALU_SrcA`=1, `ALU_SrcB`=11, `Imm_Sel`=00, `ALU_Op`=00 → WB_ALU.
- MEM_ADDR: `ALU_SrcA`=1, `ALU_SrcB`=11, `Imm_Sel`=01, `ALU_Op`=00 → MEM_RD for LW, MEM_WR for SW.
- MEM_RD: `Mem_Req`=1, `IorD`=1. Wait while `Mem_Ready`=0; on `Mem_Ready`=1 → WB_MEM.
- MEM_WR: `Mem_Req`=1, `Mem_We`=1, `IorD`=1. Wait while `Mem_Ready`=0; on `Mem_Ready`=1 → FETCH.
- WB_ALU: `Reg_Write`=1, `MemtoReg`=0 → FETCH.
- WB_MEM: `Reg_Write`=1, `MemtoReg`=1 → FETCH.
- BRANCH: `ALU_SrcA`=1, `ALU_SrcB`=00, `ALU_Op`=01, `PC_Src`=01, `PC_Write`=`Zero` → FETCH.
- JUMP: `Imm_Sel`=11, `PC_Src`=10, `PC_Write`=1 → FETCH.
- HALT: `Halted`=1; remains in HALT until reset.
- ILLEGAL: `Illegal`=1; remains in ILLEGAL until reset.
- `Instr` holds its value in every cycle where `IR_Write`=0.

## Timing
- Reset (`Rst_n`=0, asynchronous) takes effect immediately:
  - State=FETCH, `Instr`=16'h0000.
  - `Halted` and `Illegal` = 0.
  - Combinational outputs take their FETCH values; `IR_Write`/`PC_Write` follow `Mem_Ready`.
- Release of reset is synchronous: the first FETCH cycle is the first rising edge with `Rst_n`=1.
- Cycles per instruction with zero-wait memory (`Mem_Ready` held 1):
  - R-type / ADDI: 4
  - LW: 5
  - SW: 4
  - BEQ / JMP: 3
  - Each stall cycle (`Mem_Ready`=0) in FETCH, MEM_RD or MEM_WR adds one cycle.
- Memory handshake:
  - `Mem_Req`, `IorD` and `Mem_We` stay constant for the whole stall.
  - A request completes in exactly the cycle in which `Mem_Ready`=1 is sampled.
  - `Mem_Ready` outside a requesting state is ignored.
- `Instr` changes on the edge ending a FETCH cycle that sampled `Mem_Ready`=1. `Imm_Sel` for the new instruction is valid from DECODE onward.
- Reset asserted mid-stall: `Mem_Req` drops in the same cycle and no register write occurs.

## Test plan
- Reset with `Mem_Ready`=1: assert `Rst_n`=0 mid-cycle → `State`=0 and `Instr`=0000 without waiting for a clock edge. After release, the first edge loads `Mem_Rdata`=16'h0123 into `Instr`.
- R-type 16'h0123, zero-wait: states 0,1,2,7 over 4 cycles. `Reg_Write`=1 only in WB_ALU; `ALU_Op`=10 in EXEC_R.
- LW 16'h2345 with 2 stall cycles in MEM_RD: states 0,1,4,5,5,5,8. `Imm_Sel`=01 in MEM_ADDR; `MemtoReg`=1 in WB_MEM.
- BEQ 16'h4007: `Zero`=1 gives `PC_Write`=1 and `PC_Src`=01 in BRANCH. Repeat with `Zero`=0 → `PC_Write`=0. Both cases return to FETCH after 3 cycles.
- JMP 16'h5ABC then HALT 16'hF000: JUMP asserts `Imm_Sel`=11 and `PC_Write`=1. HALT sets `Halted`=1, and `Mem_Req` stays 0 for 10 cycles.
- Opcode 16'h7000 → ILLEGAL with `Illegal`=1, held until reset. Asserting reset during a FETCH stall → `Mem_Req`=0 immediately.

Source files
------------

// File: rtl/mc_ctrl_fsm.sv
// rtl/mc_ctrl_fsm.sv - multi-cycle control FSM with instruction register for the 16-bit RISC core
// Outputs decode combinationally from the registered state; Instr loads on a completed fetch.
module mc_ctrl_fsm (
    input  logic        Clk,
    input  logic        Rst_n,
    input  logic        Mem_Ready,
    input  logic [15:0] Mem_Rdata,
    input  logic        Zero,
    output logic [15:0] Instr,
    output logic [1:0]  Imm_Sel,
    output logic        Mem_Req,
    output logic        Mem_We,
    output logic        IorD,
    output logic        IR_Write,
    output logic        PC_Write,
    output logic        Reg_Write,
    output logic        MemtoReg,
    output logic        ALU_SrcA,
    output logic [1:0]  ALU_SrcB,
    output logic [1:0]  ALU_Op,
    output logic [1:0]  PC_Src,
    output logic        Halted,
    output logic        Illegal,
    output logic [3:0]  State
);

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_EXEC_R   = 4'd2,
        S_EXEC_I   = 4'd3,
        S_MEM_ADDR = 4'd4,
        S_MEM_RD   = 4'd5,
        S_MEM_WR   = 4'd6,
        S_WB_ALU   = 4'd7,
        S_WB_MEM   = 4'd8,
        S_BRANCH   = 4'd9,
        S_JUMP     = 4'd10,
        S_HALT     = 4'd11,
        S_ILLEGAL  = 4'd12
    } state_t;

    localparam logic [3:0] OP_RTYPE = 4'b0000;
    localparam logic [3:0] OP_ADDI  = 4'b0001;
    localparam logic [3:0] OP_LW    = 4'b0010;
    localparam logic [3:0] OP_SW    = 4'b0011;
    localparam logic [3:0] OP_BEQ   = 4'b0100;
    localparam logic [3:0] OP_JMP   = 4'b0101;
    localparam logic [3:0] OP_HALT  = 4'b1111;

    state_t      state_q, state_d;
    logic [15:0] instr_q, instr_d;
    logic [3:0]  opcode;
    logic        mem_req_s;
    logic        mem_we_s;

    assign opcode = instr_q[15:12];

    always_comb begin
        state_d = state_q;
        instr_d = instr_q;
        case (state_q)
            S_FETCH: begin
                if (Mem_Ready) begin
                    instr_d = Mem_Rdata;
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                case (opcode)
                    OP_RTYPE:      state_d = S_EXEC_R;
                    OP_ADDI:       state_d = S_EXEC_I;
                    OP_LW, OP_SW:  state_d = S_MEM_ADDR;
                    OP_BEQ:        state_d = S_BRANCH;
                    OP_JMP:        state_d = S_JUMP;
                    OP_HALT:       state_d = S_HALT;
                    default:       state_d = S_ILLEGAL;
                endcase
            end
            S_EXEC_R, S_EXEC_I: state_d = S_WB_ALU;
            S_MEM_ADDR: state_d = (opcode == OP_LW) ? S_MEM_RD : S_MEM_WR;
            S_MEM_RD: begin
                if (Mem_Ready) state_d = S_WB_MEM;
            end
            S_MEM_WR: begin
                if (Mem_Ready) state_d = S_FETCH;
            end
            S_WB_ALU, S_WB_MEM, S_BRANCH, S_JUMP: state_d = S_FETCH;
            S_HALT:    state_d = S_HALT;
            S_ILLEGAL: state_d = S_ILLEGAL;
            default:   state_d = S_ILLEGAL;
        endcase
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q <= S_FETCH;
            instr_q <= 16'h0000;
        end else begin
            state_q <= state_d;
            instr_q <= instr_d;
        end
    end

    always_comb begin
        mem_req_s = 1'b0;
        mem_we_s  = 1'b0;
        IorD      = 1'b0;
        IR_Write  = 1'b0;
        PC_Write  = 1'b0;
        Reg_Write = 1'b0;
        MemtoReg  = 1'b0;
        ALU_SrcA  = 1'b0;
        ALU_SrcB  = 2'b00;
        ALU_Op    = 2'b00;
        PC_Src    = 2'b00;
        Imm_Sel   = 2'b00;
        Halted    = 1'b0;
        Illegal   = 1'b0;
        case (state_q)
            S_FETCH: begin
                mem_req_s = 1'b1;
                ALU_SrcB  = 2'b01;
                IR_Write  = Mem_Ready;
                PC_Write  = Mem_Ready;
            end
            // Speculatively forms PC + branch offset while the opcode is decoded.
            S_DECODE: begin
                ALU_SrcB = 2'b11;
                Imm_Sel  = 2'b10;
            end
            S_EXEC_R: begin
                ALU_SrcA = 1'b1;
                ALU_Op   = 2'b10;
            end
            S_EXEC_I: begin
                ALU_SrcA = 1'b1;
                ALU_SrcB = 2'b11;
            end
            S_MEM_ADDR: begin
                ALU_SrcA = 1'b1;
                ALU_SrcB = 2'b11;
                Imm_Sel  = 2'b01;
            end
            S_MEM_RD: begin
                mem_req_s = 1'b1;
                IorD      = 1'b1;
            end
            S_MEM_WR: begin
                mem_req_s = 1'b1;
                mem_we_s  = 1'b1;
                IorD      = 1'b1;
            end
            S_WB_ALU: Reg_Write = 1'b1;
            S_WB_MEM: begin
                Reg_Write = 1'b1;
                MemtoReg  = 1'b1;
            end
            S_BRANCH: begin
                ALU_SrcA = 1'b1;
                ALU_Op   = 2'b01;
                PC_Src   = 2'b01;
                PC_Write = Zero;
            end
            S_JUMP: begin
                Imm_Sel  = 2'b11;
                PC_Src   = 2'b10;
                PC_Write = 1'b1;
            end
            S_HALT:    Halted  = 1'b1;
            S_ILLEGAL: Illegal = 1'b1;
            default: ;
        endcase
    end

    // A request must vanish as soon as reset asserts, even though reset parks us in FETCH.
    assign Mem_Req = mem_req_s & Rst_n;
    assign Mem_We  = mem_we_s & Rst_n;
    assign Instr   = instr_q;
    assign State   = state_q;

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// tb/tb_mc_ctrl_fsm.sv - scoreboard bench for mc_ctrl_fsm
module tb_mc_ctrl_fsm;

    logic        Clk = 1'b0;
    logic        Rst_n;
    logic        Mem_Ready;
    logic [15:0] Mem_Rdata;
    logic        Zero;
    logic [15:0] Instr;
    logic [1:0]  Imm_Sel;
    logic        Mem_Req, Mem_We, IorD, IR_Write, PC_Write, Reg_Write, MemtoReg, ALU_SrcA;
    logic [1:0]  ALU_SrcB, ALU_Op, PC_Src;
    logic        Halted, Illegal;
    logic [3:0]  State;

    mc_ctrl_fsm dut (
        .Clk(Clk), .Rst_n(Rst_n), .Mem_Ready(Mem_Ready), .Mem_Rdata(Mem_Rdata), .Zero(Zero),
        .Instr(Instr), .Imm_Sel(Imm_Sel), .Mem_Req(Mem_Req), .Mem_We(Mem_We), .IorD(IorD),
        .IR_Write(IR_Write), .PC_Write(PC_Write), .Reg_Write(Reg_Write), .MemtoReg(MemtoReg),
        .ALU_SrcA(ALU_SrcA), .ALU_SrcB(ALU_SrcB), .ALU_Op(ALU_Op), .PC_Src(PC_Src),
        .Halted(Halted), .Illegal(Illegal), .State(State)
    );

    always #5 Clk = ~Clk;

    typedef struct packed {
        logic [15:0] id;
        logic [3:0]  st;
        logic [17:0] ctl;
        logic [15:0] ins;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;
    int   vec_id = 0;

    // {req, we, iord, irw, pcw, rw, m2r, srca, srcb, op, pcs, imm, halt, ill}
    function automatic logic [17:0] exp_ctl(input logic [3:0] st, input logic rdy, input logic z);
        case (st)
            4'd0:  return {1'b1, 1'b0, 1'b0, rdy, rdy, 1'b0, 1'b0, 1'b0, 2'b01, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0};
            4'd1:  return {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b11, 2'b00, 2'b00, 2'b10, 1'b0, 1'b0};
            4'd2:  return {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 2'b10, 2'b00, 2'b00, 1'b0, 1'b0};
            4'd3:  return {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b11, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0};
            4'd4:  return {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b11, 2'b00, 2'b00, 2'b01, 1'b0, 1'b0};
            4'd5:  return {1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0};
            4'd6:  return {1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0};
            4'd7:  return {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0};
            4'd8:  return {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0};
            4'd9:  return {1'b0, 1'b0, 1'b0, 1'b0, z,    1'b0, 1'b0, 1'b1, 2'b00, 2'b01, 2'b01, 2'b00, 1'b0, 1'b0};
            4'd10: return {1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b10, 2'b11, 1'b0, 1'b0};
            4'd11: return {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 1'b1, 1'b0};
            4'd12: return {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 1'b1};
            default: return 18'h0;
        endcase
    endfunction

    task automatic check(input string nm, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, got, want);
        end
    endtask

    // Drive one cycle's inputs just after the edge and queue the state/outputs expected for it.
    task automatic step(input logic [3:0] st, input logic rdy, input logic [15:0] rd,
                        input logic z, input logic [15:0] ins);
        exp_t e;
        Mem_Ready = rdy;
        Mem_Rdata = rd;
        Zero      = z;
        e.id  = 16'(vec_id);
        e.st  = st;
        e.ctl = exp_ctl(st, rdy, z);
        e.ins = ins;
        exp_q.push_back(e);
        vec_id++;
        @(posedge Clk);
        #1;
    endtask

    always @(negedge Clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            total++;
            if (State !== e.st) begin
                bad++;
                $display("FAIL vec%0d state: got %0d want %0d", e.id, State, e.st);
            end
            total++;
            if ({Mem_Req, Mem_We, IorD, IR_Write, PC_Write, Reg_Write, MemtoReg, ALU_SrcA,
                 ALU_SrcB, ALU_Op, PC_Src, Imm_Sel, Halted, Illegal} !== e.ctl) begin
                bad++;
                $display("FAIL vec%0d ctl: got %b want %b", e.id,
                         {Mem_Req, Mem_We, IorD, IR_Write, PC_Write, Reg_Write, MemtoReg, ALU_SrcA,
                          ALU_SrcB, ALU_Op, PC_Src, Imm_Sel, Halted, Illegal}, e.ctl);
            end
            total++;
            if (Instr !== e.ins) begin
                bad++;
                $display("FAIL vec%0d instr: got %h want %h", e.id, Instr, e.ins);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        Rst_n = 1'b1; Mem_Ready = 1'b1; Mem_Rdata = 16'h0123; Zero = 1'b0;
        #7 Rst_n = 1'b0;
        #1;
        check("rst_state", 32'(State), 32'd0);
        check("rst_instr", 32'(Instr), 32'h0000);
        check("rst_memreq", 32'(Mem_Req), 32'd0);
        check("rst_flags", 32'({Halted, Illegal}), 32'd0);
        @(posedge Clk); #1 Rst_n = 1'b1;

        step(4'd0, 1'b1, 16'h0123, 1'b0, 16'h0000);
        step(4'd1, 1'b1, 16'hDEAD, 1'b0, 16'h0123);
        step(4'd2, 1'b1, 16'hDEAD, 1'b0, 16'h0123);
        step(4'd7, 1'b1, 16'hDEAD, 1'b0, 16'h0123);

        step(4'd0, 1'b1, 16'h1000, 1'b0, 16'h0123);
        step(4'd1, 1'b1, 16'hDEAD, 1'b0, 16'h1000);
        step(4'd3, 1'b1, 16'hDEAD, 1'b0, 16'h1000);
        step(4'd7, 1'b1, 16'hDEAD, 1'b0, 16'h1000);

        step(4'd0, 1'b1, 16'h2345, 1'b0, 16'h1000);
        step(4'd1, 1'b1, 16'hDEAD, 1'b0, 16'h2345);
        step(4'd4, 1'b1, 16'hDEAD, 1'b0, 16'h2345);
        step(4'd5, 1'b0, 16'hDEAD, 1'b0, 16'h2345);
        step(4'd5, 1'b0, 16'hDEAD, 1'b0, 16'h2345);
        step(4'd5, 1'b1, 16'h5555, 1'b0, 16'h2345);
        step(4'd8, 1'b1, 16'hDEAD, 1'b0, 16'h2345);

        step(4'd0, 1'b0, 16'h3456, 1'b0, 16'h2345);
        step(4'd0, 1'b1, 16'h3456, 1'b0, 16'h2345);
        step(4'd1, 1'b1, 16'hDEAD, 1'b0, 16'h3456);
        step(4'd4, 1'b1, 16'hDEAD, 1'b0, 16'h3456);
        step(4'd6, 1'b0, 16'hDEAD, 1'b0, 16'h3456);
        step(4'd6, 1'b1, 16'hDEAD, 1'b0, 16'h3456);

        step(4'd0, 1'b1, 16'h4007, 1'b1, 16'h3456);
        step(4'd1, 1'b1, 16'hDEAD, 1'b1, 16'h4007);
        step(4'd9, 1'b1, 16'hDEAD, 1'b1, 16'h4007);
        step(4'd0, 1'b1, 16'h4007, 1'b0, 16'h4007);
        step(4'd1, 1'b1, 16'hDEAD, 1'b0, 16'h4007);
        step(4'd9, 1'b1, 16'hDEAD, 1'b0, 16'h4007);

        step(4'd0, 1'b1, 16'h5ABC, 1'b0, 16'h4007);
        step(4'd1, 1'b1, 16'hDEAD, 1'b0, 16'h5ABC);
        step(4'd10, 1'b1, 16'hDEAD, 1'b0, 16'h5ABC);

        step(4'd0, 1'b1, 16'hF000, 1'b0, 16'h5ABC);
        step(4'd1, 1'b1, 16'hDEAD, 1'b0, 16'hF000);
        for (int i = 0; i < 10; i++)
            step(4'd11, 1'(i % 2), 16'h0000, 1'b0, 16'hF000);

        #3 Rst_n = 1'b0;
        #1;
        check("halt_rst_state", 32'(State), 32'd0);
        check("halt_rst_instr", 32'(Instr), 32'h0000);
        check("halt_rst_halted", 32'(Halted), 32'd0);
        @(posedge Clk); #1 Rst_n = 1'b1;

        step(4'd0, 1'b1, 16'h7000, 1'b0, 16'h0000);
        step(4'd1, 1'b1, 16'hDEAD, 1'b0, 16'h7000);
        for (int i = 0; i < 3; i++)
            step(4'd12, 1'b1, 16'h0000, 1'b0, 16'h7000);

        #3 Rst_n = 1'b0;
        #1;
        check("ill_rst_illegal", 32'(Illegal), 32'd0);
        check("ill_rst_state", 32'(State), 32'd0);
        @(posedge Clk); #1 Rst_n = 1'b1;

        step(4'd0, 1'b0, 16'hBEEF, 1'b0, 16'h0000);
        Mem_Ready = 1'b0;
        #3;
        check("stall_memreq", 32'(Mem_Req), 32'd1);
        #1 Rst_n = 1'b0;
        #1;
        check("stall_rst_memreq", 32'(Mem_Req), 32'd0);
        check("stall_rst_state", 32'(State), 32'd0);
        Mem_Ready = 1'b1;
        @(posedge Clk); #1;
        check("stall_rst_nowrite", 32'(Instr), 32'h0000);
        Rst_n = 1'b1;
        @(negedge Clk);
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
